// File: rtl/count_pkg.sv
// Shared definitions for the up-counter checker: FSM state encoding and the
// width of the compared-cycle counter.
package count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_CHECK = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  localparam int CHECK_CNT_W = 16;

endpackage

// File: rtl/count_ref_model.sv
// Shadow copy of the DFF up-counter. It follows the same reset/enable inputs as
// the real counter and flags the edge on which it rolls over to zero.
module count_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_exp,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_exp;

  // A clear on the same edge as an enable wins, so no rollover happens then.
  assign o_wrap = !i_clear && i_enable && (r_exp == '1);
  assign o_exp  = r_exp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!i_rst_n)      r_exp <= '0;
    else if (i_clear)  r_exp <= '0;
    else if (i_enable) r_exp <= r_exp + WIDTH'(1);
  end

endmodule

// File: rtl/count_checker.sv
// On-line checker for the DFF up-counter: shadow model, synchronisation FSM,
// registered mismatch pulse, saturating statistics and a pass flag.
import count_pkg::*;

module count_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_WIDTH = 8,
  parameter int MIN_CHECK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dut_reset,
  input  logic                 dut_enable,
  input  logic [WIDTH-1:0]     dut_count,
  input  logic                 check_en,
  output logic                 mismatch,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [ERR_WIDTH-1:0] wrap_count,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_got,
  output logic [1:0]           state,
  output logic                 pass
);

  state_t                 r_state, w_state_nxt;
  logic [WIDTH-1:0]       w_exp;
  logic                   w_wrap;
  logic                   w_cmp, w_bad, w_wrap_inc;
  logic [ERR_WIDTH-1:0]   r_err, r_wrap, w_err_nxt;
  logic [CHECK_CNT_W-1:0] r_chk, w_chk_nxt;
  logic [WIDTH-1:0]       r_first_exp, r_first_got;
  logic                   r_mismatch, r_pass;

  count_ref_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_clear  (dut_reset),
    .i_enable (dut_enable),
    .o_exp    (w_exp),
    .o_wrap   (w_wrap)
  );

  // NOTE: the default on the first line of the block guarantees every path
  // assigns w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (dut_reset) w_state_nxt = ST_SYNC;
      ST_SYNC:  if (!dut_reset) w_state_nxt = ST_CHECK;
      ST_CHECK: if (dut_reset) w_state_nxt = ST_SYNC;
                else if (!check_en) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (dut_reset) w_state_nxt = ST_SYNC;
                else if (check_en) w_state_nxt = ST_CHECK;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Model and counter output are both registered on the same edge, so the
  // comparison is between current-cycle values with no alignment delay.
  assign w_cmp      = (r_state == ST_CHECK) && check_en && !dut_reset;
  assign w_bad      = w_cmp && (dut_count != w_exp);
  assign w_wrap_inc = w_wrap && (r_state != ST_IDLE);
  assign w_err_nxt  = (w_bad && (r_err != '1)) ? r_err + ERR_WIDTH'(1) : r_err;
  assign w_chk_nxt  = (w_cmp && (r_chk != '1)) ? r_chk + CHECK_CNT_W'(1) : r_chk;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_err       <= '0;
      r_wrap      <= '0;
      r_chk       <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
      r_mismatch  <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err      <= w_err_nxt;
      r_chk      <= w_chk_nxt;
      r_mismatch <= w_bad;
      if (w_wrap_inc && (r_wrap != '1)) r_wrap <= r_wrap + ERR_WIDTH'(1);
      // Only the very first failure since reset is captured.
      if (w_bad && (r_err == '0)) begin
        r_first_exp <= w_exp;
        r_first_got <= dut_count;
      end
      r_pass <= (w_chk_nxt >= CHECK_CNT_W'(MIN_CHECK)) && (w_err_nxt == '0);
    end
  end

  assign mismatch   = r_mismatch;
  assign err_count  = r_err;
  assign wrap_count = r_wrap;
  assign first_exp  = r_first_exp;
  assign first_got  = r_first_got;
  assign state      = r_state;
  assign pass       = r_pass;

endmodule

// File: tb/tb_count_checker.sv
// Directed and randomized bench for count_checker against a behavioural model
// of the counter-checking rules, kept as plain integers.
module tb_count_checker;

  localparam int W = 4, EW = 8, MINC = 16;
  localparam int MODE_IDLE = 0, MODE_SYNC = 1, MODE_CHECK = 2, MODE_HOLD = 3;

  logic          clk = 1'b0;
  logic          reset, dut_reset, dut_enable, check_en;
  logic [W-1:0]  dut_count;
  logic          mismatch, pass;
  logic [EW-1:0] err_count, wrap_count;
  logic [W-1:0]  first_exp, first_got;
  logic [1:0]    state;

  count_checker #(.WIDTH(W), .ERR_WIDTH(EW), .MIN_CHECK(MINC)) dut (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .dut_enable(dut_enable),
    .dut_count(dut_count), .check_en(check_en), .mismatch(mismatch),
    .err_count(err_count), .wrap_count(wrap_count), .first_exp(first_exp),
    .first_got(first_got), .state(state), .pass(pass)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int ctr = 0;                    // the counter being observed (well-behaved)
  bit force_en = 0;
  int force_val = 0;
  int m_exp = 0, m_mode = MODE_IDLE, m_err = 0, m_wrap = 0, m_checked = 0;
  int m_mis = 0, m_fexp = 0, m_fgot = 0, m_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int got;
    bit cmp, bad;
    got = int'(dut_count);
    if (!reset) begin
      m_exp = 0; m_mode = MODE_IDLE; m_err = 0; m_wrap = 0; m_checked = 0;
      m_mis = 0; m_fexp = 0; m_fgot = 0; m_pass = 0;
      return;
    end
    cmp = (m_mode == MODE_CHECK) && check_en && !dut_reset;
    bad = cmp && (got != m_exp);
    m_mis = bad;
    if (bad && m_err == 0) begin m_fexp = m_exp; m_fgot = got; end
    if (bad && m_err < 255) m_err++;
    if (cmp && m_checked < 65535) m_checked++;
    if (m_mode != MODE_IDLE && !dut_reset && dut_enable && m_exp == 15 && m_wrap < 255)
      m_wrap++;
    m_exp = dut_reset ? 0 : dut_enable ? (m_exp + 1) % 16 : m_exp;
    case (m_mode)
      MODE_IDLE:  if (dut_reset) m_mode = MODE_SYNC;
      MODE_SYNC:  if (!dut_reset) m_mode = MODE_CHECK;
      MODE_CHECK: m_mode = dut_reset ? MODE_SYNC : (!check_en ? MODE_HOLD : MODE_CHECK);
      default:    m_mode = dut_reset ? MODE_SYNC : (check_en ? MODE_CHECK : MODE_HOLD);
    endcase
    m_pass = (m_checked >= MINC) && (m_err == 0);
  endtask

  task automatic check_all(input string where);
    check({where, ".mismatch"},  mismatch,   m_mis);
    check({where, ".err_count"}, err_count,  m_err);
    check({where, ".wrap"},      wrap_count, m_wrap);
    check({where, ".first_exp"}, first_exp,  m_fexp);
    check({where, ".first_got"}, first_got,  m_fgot);
    check({where, ".state"},     state,      m_mode);
    check({where, ".pass"},      pass,       m_pass);
  endtask

  // Apply the current inputs for one clock, advance model and counter, check.
  task automatic step(input string where);
    int ctr_nxt;
    dut_count = force_en ? W'(force_val) : W'(ctr);
    ctr_nxt = dut_reset ? 0 : dut_enable ? (ctr + 1) % 16 : ctr;
    model_edge();
    @(posedge clk);
    #1;
    ctr = ctr_nxt;
    check_all(where);
  endtask

  initial begin
    reset = 1'b0; dut_reset = 1'b0; dut_enable = 1'b0; check_en = 1'b0;
    dut_count = '0;

    // 1: checker reset, then idle without any counter reset
    repeat (2) step("t1_reset");
    reset = 1'b1;
    repeat (4) step("t1_idle");
    check("t1_state_idle", state, MODE_IDLE);
    check("t1_pass_low", pass, 0);

    // 2: synchronise and run a correct counter for 50 cycles
    dut_reset = 1'b1;
    repeat (3) step("t2_sync");
    check("t2_state_sync", state, MODE_SYNC);
    dut_reset = 1'b0; dut_enable = 1'b1; check_en = 1'b1;
    repeat (50) step("t2_run");
    check("t2_err_zero", err_count, 0);
    check("t2_wrap_three", wrap_count, 3);
    check("t2_pass_high", pass, 1);

    // 3: enable low with held count, then a single wrong value at exp=5
    dut_enable = 1'b0;
    repeat (5) step("t3_hold_en");
    dut_enable = 1'b1;
    for (int k = 0; k < 32 && m_exp != 5; k++) step("t3_seek5");
    if (m_exp != 5) begin
      n_bad++;
      $display("FAIL t3_seek5: model never reached 5 (at %0d)", m_exp);
    end
    dut_enable = 1'b0; force_en = 1; force_val = 7;
    step("t3_bad");
    check("t3_mismatch_pulse", mismatch, 1);
    check("t3_err_one", err_count, 1);
    check("t3_first_exp", first_exp, 5);
    check("t3_first_got", first_got, 7);
    force_en = 0;
    step("t3_after");
    check("t3_mismatch_clear", mismatch, 0);
    check("t3_pass_low", pass, 0);

    // 4: comparisons disabled with a wrong count, then re-enabled
    check_en = 1'b0; dut_enable = 1'b1; force_en = 1;
    for (int k = 0; k < 10; k++) begin
      force_val = (ctr + 3) % 16;
      step("t4_hold");
    end
    check("t4_state_hold", state, MODE_HOLD);
    check("t4_err_kept", err_count, 1);
    force_en = 0; check_en = 1'b1;
    repeat (4) step("t4_check");
    check("t4_state_check", state, MODE_CHECK);
    check("t4_err_still", err_count, 1);

    // 5: counter reset mid-run at exp=9
    for (int k = 0; k < 32 && m_exp != 9; k++) step("t5_seek9");
    if (m_exp != 9) begin
      n_bad++;
      $display("FAIL t5_seek9: model never reached 9 (at %0d)", m_exp);
    end
    dut_reset = 1'b1;
    step("t5_reset");
    check("t5_state_sync", state, MODE_SYNC);
    check("t5_err_kept", err_count, 1);
    dut_reset = 1'b0;
    repeat (8) step("t5_resume");

    // Randomized traffic: enables, gating, counter resets and bad values
    for (int k = 0; k < 150; k++) begin
      dut_enable = 1'($urandom_range(0, 1));
      check_en   = ($urandom_range(0, 9) != 0);
      dut_reset  = ($urandom_range(0, 29) == 0);
      force_en   = ($urandom_range(0, 19) == 0);
      force_val  = $urandom_range(0, 15);
      step("rand");
    end

    // 6: drive 300 wrong values to saturate the error counter, then reset
    dut_reset = 1'b0; dut_enable = 1'b0; check_en = 1'b1; force_en = 1;
    for (int k = 0; k < 300; k++) begin
      force_val = (m_exp + 8) % 16;
      step("t6_sat");
    end
    check("t6_err_sat", err_count, 8'hFF);
    reset = 1'b0; dut_reset = 1'b1; dut_enable = 1'b1;
    step("t6_reset");
    check("t6_err_clr", err_count, 0);
    check("t6_wrap_clr", wrap_count, 0);
    check("t6_state_clr", state, MODE_IDLE);
    check("t6_first_clr", {first_exp, first_got}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
